expr_emit: RTL and testbench

EXPR_EMIT -- requirements
Module: expr_emit

---
 rtl/expr_emit.sv | 225 ++++++++++++++++++++++
 tb/tb_expr_emit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_emit.sv
// expr_emit: streams an arithmetic expression ("d0 op0 d1 ... d(n-1)") one
// ASCII character at a time over a valid/ready handshake and evaluates it
// with '*' binding tighter than '+', all arithmetic modulo 256.
module expr_emit #(
    parameter int MAX_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [3:0]               n_terms,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    output logic [7:0]               ch,
    output logic                     ch_valid,
    input  logic                     ch_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [7:0]               result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIGIT = 3'd1,
        OP    = 3'd2,
        FIN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             n_q, n_d;
    logic [3:0]             idx_q, idx_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             prod_q, prod_d;
    logic [7:0]             ch_q, ch_d;
    logic                   ch_valid_q, ch_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [7:0]             result_q, result_d;

    // Working values for the digit currently being offered.
    logic [3:0]             cur_digit;
    logic [7:0]             prod_mul;
    logic [7:0]             sum_next;
    logic [7:0]             prod_next;

    // Term i of a packed operand vector (terms beyond MAX_TERMS read as 0).
    function automatic logic [3:0] term_at(input logic [4*MAX_TERMS-1:0] d,
                                           input logic [3:0] i);
        logic [3:0] t;
        t = 4'd0;
        for (int k = 0; k < MAX_TERMS; k++) begin
            if (i == 4'(k)) t = d[4*k +: 4];
        end
        return t;
    endfunction

    // Operator bit i (1 = '*', 0 = '+').
    function automatic logic op_at(input logic [MAX_TERMS-2:0] o,
                                   input logic [3:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < MAX_TERMS - 1; k++) begin
            if (i == 4'(k)) b = o[k];
        end
        return b;
    endfunction

    // A request is legal when the count is in range and every used term is a decimal digit.
    function automatic logic req_legal(input logic [3:0] n,
                                       input logic [4*MAX_TERMS-1:0] d);
        logic ok;
        ok = (n != 4'd0) && (n <= 4'(MAX_TERMS));
        for (int k = 0; k < MAX_TERMS; k++) begin
            if ((4'(k) < n) && (d[4*k +: 4] > 4'd9)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic is_mul);
        return is_mul ? 8'h2A : 8'h2B;
    endfunction

    // Accumulator update for the digit being transferred: '*' folds into prod,
    // '+' retires prod into sum and starts a new product.
    always_comb begin
        cur_digit = term_at(digits_q, idx_q);
        prod_mul  = prod_q * {4'h0, cur_digit};
        sum_next  = sum_q;
        prod_next = {4'h0, cur_digit};
        if (idx_q == 4'd0) begin
            sum_next  = 8'h00;
            prod_next = {4'h0, cur_digit};
        end else if (op_at(ops_q, idx_q - 4'd1)) begin
            sum_next  = sum_q;
            prod_next = prod_mul;
        end else begin
            sum_next  = sum_q + prod_q;
            prod_next = {4'h0, cur_digit};
        end
    end

    // Next-state and registered-output logic; everything holds unless changed.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        digits_d   = digits_q;
        ops_d      = ops_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        ch_d       = ch_q;
        ch_valid_d = ch_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        result_d   = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d      = n_terms;
                    digits_d = digits;
                    ops_d    = ops;
                    idx_d    = 4'd0;
                    sum_d    = 8'h00;
                    prod_d   = 8'h00;
                    if (req_legal(n_terms, digits)) begin
                        state_d    = DIGIT;
                        busy_d     = 1'b1;
                        ch_valid_d = 1'b1;
                        ch_d       = digit_char(digits[3:0]);
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (ch_ready) begin
                    sum_d  = sum_next;
                    prod_d = prod_next;
                    if (idx_q == n_q - 4'd1) begin
                        state_d    = FIN;
                        ch_valid_d = 1'b0;
                        ch_d       = 8'h00;
                        done_d     = 1'b1;
                        result_d   = sum_next + prod_next;
                    end else begin
                        state_d = OP;
                        ch_d    = op_char(op_at(ops_q, idx_q));
                    end
                end
            end
            OP: begin
                if (ch_ready) begin
                    state_d = DIGIT;
                    idx_d   = idx_q + 4'd1;
                    ch_d    = digit_char(term_at(digits_q, idx_q + 4'd1));
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                ch_valid_d = 1'b0;
                ch_d       = 8'h00;
            end
        endcase
    end

    // State and output registers; clr clears everything without waiting for clk.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            n_q        <= 4'd0;
            idx_q      <= 4'd0;
            digits_q   <= '0;
            ops_q      <= '0;
            sum_q      <= 8'h00;
            prod_q     <= 8'h00;
            ch_q       <= 8'h00;
            ch_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            digits_q   <= digits_d;
            ops_q      <= ops_d;
            sum_q      <= sum_d;
            prod_q     <= prod_d;
            ch_q       <= ch_d;
            ch_valid_q <= ch_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
        end
    end

    assign ch       = ch_q;
    assign ch_valid = ch_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;

endmodule

// File: tb/tb_expr_emit.sv
// Scoreboard bench for expr_emit: stimulus pushes the expected characters,
// done/result and err events; a negedge monitor pops and compares them.
module tb_expr_emit;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  n_terms;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic [7:0]  ch;
    logic        ch_valid;
    logic        ch_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  result;

    int total = 0;
    int bad   = 0;

    localparam int K_CHAR = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    expr_emit #(.MAX_TERMS(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .n_terms  (n_terms),
        .digits   (digits),
        .ops      (ops),
        .ch       (ch),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(K_CHAR, s[i]);
    endtask

    task automatic pop_chk(input string name, input int kind, input logic [7:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event got=%0h expected=none", name, act);
        end else begin
            e = sb.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            chk(name, act, e.val);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic       res_pending;
        logic [7:0] res_exp;
        logic       hold_pending;
        logic [7:0] hold_ch;
        res_pending  = 1'b0;
        res_exp      = 8'h00;
        hold_pending = 1'b0;
        hold_ch      = 8'h00;
        forever begin
            @(negedge clk);
            if (res_pending) begin
                chk("result", result, res_exp);
                res_pending = 1'b0;
            end
            if (hold_pending) begin
                chk("hold_ch", ch, hold_ch);
                chk("hold_valid", ch_valid, 1);
                hold_pending = 1'b0;
            end
            if (!ch_valid) chk("idle_ch_zero", ch, 0);
            if (ch_valid && !ch_ready) begin
                hold_pending = 1'b1;
                hold_ch      = ch;
            end
            if (ch_valid && ch_ready) pop_chk("char", K_CHAR, ch);
            if (done) begin
                exp_t e;
                chk("done_chvalid", ch_valid, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done: unexpected done pulse got=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", K_DONE, e.kind);
                    res_pending = 1'b1;
                    res_exp     = e.val;
                end
            end
            if (err) pop_chk("err_result", K_ERR, result);
        end
    end

    // Issue one legal request and wait (bounded) for done; optionally stall on '+'
    // and optionally poke start while busy.
    task automatic run_expr(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o,
                            input string exp_s, input logic [7:0] exp_res,
                            input int stall_n, input bit poke, input int exp_cycles);
        int  cycles;
        int  stalls;
        bit  got;
        push_str(exp_s);
        push(K_DONE, exp_res);
        @(posedge clk); #1;
        n_terms  = n;
        digits   = d;
        ops      = o;
        start    = 1'b1;
        ch_ready = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        stalls = stall_n;
        got    = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if (ch_valid && ch == 8'h2B && stalls > 0) begin
                ch_ready = 1'b0;
                stalls--;
            end else begin
                ch_ready = 1'b1;
            end
            start = (poke && cycles == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            cycles++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        ch_ready = 1'b1;
        chk({exp_s, "_done_seen"}, got, 1);
        chk({exp_s, "_cycles"}, cycles, exp_cycles);
        @(negedge clk);
        chk({exp_s, "_done_once"}, done, 0);
        chk({exp_s, "_busy_low"}, busy, 0);
    endtask

    task automatic run_err(input string name, input logic [3:0] n, input logic [31:0] d,
                           input logic [7:0] keep_res);
        push(K_ERR, keep_res);
        @(posedge clk); #1;
        n_terms = n;
        digits  = d;
        ops     = 7'd0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({name, "_err_pulse"}, err, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_no_valid"}, ch_valid, 0);
        @(negedge clk);
        chk({name, "_err_one_cycle"}, err, 0);
        chk({name, "_no_valid2"}, ch_valid, 0);
    endtask

    initial begin
        int  xfers;
        clr      = 1'b1;
        start    = 1'b0;
        n_terms  = 4'd0;
        digits   = 32'h0;
        ops      = 7'd0;
        ch_ready = 1'b1;

        #3;
        chk("rst_ch", ch, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        // Single term: "7".
        run_expr(4'd1, 32'h0000_0007, 7'd0, "7", 8'h07, 0, 1'b0, 2);
        // "2+3*4" = 14, with a start pulse while busy that must be ignored.
        run_expr(4'd3, 32'h0000_0432, 7'b0000010, "2+3*4", 8'h0E, 0, 1'b1, 6);
        // Same request with a 3-cycle stall while '+' is offered.
        run_expr(4'd3, 32'h0000_0432, 7'b0000010, "2+3*4", 8'h0E, 3, 1'b0, 9);
        // "9*9*9*9" = 6561 mod 256 = 0xA1.
        run_expr(4'd4, 32'h0000_9999, 7'b0000111, "9*9*9*9", 8'hA1, 0, 1'b0, 8);

        // Rejections leave result at 0xA1.
        run_err("bad_digit", 4'd2, 32'h0000_00A3, 8'hA1);
        run_err("zero_terms", 4'd0, 32'h0000_0000, 8'hA1);
        run_err("too_many", 4'd9, 32'h0000_0000, 8'hA1);

        // Unused terms may hold non-decimal values: "5+4" = 9.
        run_expr(4'd2, 32'hFFFF_FF45, 7'b1111110, "5+4", 8'h09, 0, 1'b0, 4);
        // All eight terms: "1+2+3+4+5+6+7+8" = 36 = 0x24.
        run_expr(4'd8, 32'h8765_4321, 7'b0000000, "1+2+3+4+5+6+7+8", 8'h24, 0, 1'b0, 16);

        // clr after the third transfer of "2+3*4".
        push_str("2+3*4");
        push(K_DONE, 8'h0E);
        @(posedge clk); #1;
        n_terms  = 4'd3;
        digits   = 32'h0000_0432;
        ops      = 7'b0000010;
        start    = 1'b1;
        ch_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        xfers = 0;
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            if (ch_valid && ch_ready) xfers++;
            if (xfers == 3) break;
        end
        chk("clr_three_xfers", xfers, 3);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        chk("clr_ch", ch, 0);
        chk("clr_valid", ch_valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_err", err, 0);
        chk("clr_result", result, 0);
        #1 clr = 1'b0;
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("clr_no_done", done, 0);
        end
        run_expr(4'd3, 32'h0000_0432, 7'b0000010, "2+3*4", 8'h0E, 0, 1'b0, 6);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
